// File: rtl/uart_date_pkg.sv
// Shared types and constants for the UART date-set frame parser.
package uart_date_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DIGITS = 2'd1,
      TERM   = 2'd2,
      CHECK  = 2'd3
   } state_t;

   localparam logic [7:0] HDR_CHAR_DEF  = 8'h44;  // 'D'
   localparam logic [7:0] TERM_CHAR_DEF = 8'h0D;  // CR
   localparam logic [7:0] ASCII_ZERO    = 8'h30;
   localparam logic [7:0] ASCII_NINE    = 8'h39;

   // Power-on date, identical to the calendar counter's own reset date
   localparam logic [6:0] RST_YEAR  = 7'd24;
   localparam logic [6:0] RST_MONTH = 7'd2;
   localparam logic [6:0] RST_DAY   = 7'd2;

   // Month length; year 00 counts as a leap year. Unknown months give 0,
   // so any day compares as out of range.
   function automatic logic [6:0] days_in_month(input logic [6:0] month,
                                                input logic [6:0] year);
      logic [6:0] dim;
      case (month)
         7'd1, 7'd3, 7'd5, 7'd7, 7'd8, 7'd10, 7'd12: dim = 7'd31;
         7'd4, 7'd6, 7'd9, 7'd11:                    dim = 7'd30;
         7'd2:    dim = ((year % 7'd4) == 7'd0) ? 7'd29 : 7'd28;
         default: dim = 7'd0;
      endcase
      return dim;
   endfunction

endpackage

// File: rtl/uart_date_parser_date_check.sv
// Combinational conversion of six BCD digits (YYMMDD) into binary fields
// plus a calendar validity flag.
module date_check
   import uart_date_pkg::*;
(
   input  logic [3:0] d0,
   input  logic [3:0] d1,
   input  logic [3:0] d2,
   input  logic [3:0] d3,
   input  logic [3:0] d4,
   input  logic [3:0] d5,
   output logic [6:0] yy,
   output logic [6:0] mm,
   output logic [6:0] dd,
   output logic       valid
);

   // Tens*10 + units at 7 bits (max 99), then range-check month and day
   always_comb begin
      yy    = 7'(d0) * 7'd10 + 7'(d1);
      mm    = 7'(d2) * 7'd10 + 7'(d3);
      dd    = 7'(d4) * 7'd10 + 7'(d5);
      valid = (mm >= 7'd1) && (mm <= 7'd12) &&
              (dd >= 7'd1) && (dd <= days_in_month(mm, yy));
   end

endmodule

// File: rtl/uart_date_parser.sv
// Parses 'D' YY MM DD CR frames from the UART receiver and emits a
// validated binary date with a one-cycle load strobe for the calendar.
module uart_date_parser
   import uart_date_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
   parameter logic [7:0]  HDR_CHAR       = HDR_CHAR_DEF,
   parameter logic [7:0]  TERM_CHAR      = TERM_CHAR_DEF
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   output logic [6:0] day_out,
   output logic [6:0] month_out,
   output logic [6:0] year_out,
   output logic       load_pulse,
   output logic       frame_err,
   output logic       busy
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
   // Abort on the edge at which the idle count would reach TIMEOUT_CYCLES-1
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 2);

   state_t           state, state_nxt;
   logic [2:0]       idx, idx_nxt;
   logic [CNT_W-1:0] tmo_cnt, tmo_cnt_nxt;
   logic [3:0]       digit [6];
   logic             digit_we;
   logic             load_nxt, err_nxt;
   logic             is_digit, is_hdr, tmo_hit;
   logic [6:0]       chk_yy, chk_mm, chk_dd;
   logic             chk_valid;

   assign is_digit = (rx_data >= ASCII_ZERO) && (rx_data <= ASCII_NINE);
   assign is_hdr   = (rx_data == HDR_CHAR);
   assign tmo_hit  = !rx_valid && (tmo_cnt == TMO_LAST);

   date_check u_date_check (
      .d0    (digit[0]),
      .d1    (digit[1]),
      .d2    (digit[2]),
      .d3    (digit[3]),
      .d4    (digit[4]),
      .d5    (digit[5]),
      .yy    (chk_yy),
      .mm    (chk_mm),
      .dd    (chk_dd),
      .valid (chk_valid)
   );

   // State register
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next-state, digit index, idle counter and strobe decisions
   always_comb begin
      state_nxt   = state;
      idx_nxt     = idx;
      tmo_cnt_nxt = '0;
      digit_we    = 1'b0;
      load_nxt    = 1'b0;
      err_nxt     = 1'b0;
      case (state)
         IDLE: begin
            if (rx_valid && is_hdr) begin
               state_nxt = DIGITS;
               idx_nxt   = 3'd0;
            end
         end
         DIGITS: begin
            if (rx_valid) begin
               if (is_digit) begin
                  digit_we = 1'b1;
                  if (idx == 3'd5) begin
                     state_nxt = TERM;
                     idx_nxt   = 3'd0;
                  end else begin
                     idx_nxt = idx + 3'd1;
                  end
               end else if (is_hdr) begin
                  idx_nxt = 3'd0;
               end else begin
                  err_nxt   = 1'b1;
                  state_nxt = IDLE;
               end
            end else if (tmo_hit) begin
               err_nxt   = 1'b1;
               state_nxt = IDLE;
            end else begin
               tmo_cnt_nxt = tmo_cnt + 1'b1;
            end
         end
         TERM: begin
            if (rx_valid) begin
               if (rx_data == TERM_CHAR) begin
                  state_nxt = CHECK;
               end else begin
                  err_nxt   = 1'b1;
                  state_nxt = IDLE;
               end
            end else if (tmo_hit) begin
               err_nxt   = 1'b1;
               state_nxt = IDLE;
            end else begin
               tmo_cnt_nxt = tmo_cnt + 1'b1;
            end
         end
         CHECK: begin
            state_nxt = IDLE;
            load_nxt  = chk_valid;
            err_nxt   = !chk_valid;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs decoded from state
   always_comb begin
      busy = (state != IDLE);
   end

   // Control registers, strobes and the held date
   always_ff @(posedge clk) begin
      if (reset) begin
         idx        <= 3'd0;
         tmo_cnt    <= '0;
         load_pulse <= 1'b0;
         frame_err  <= 1'b0;
         year_out   <= RST_YEAR;
         month_out  <= RST_MONTH;
         day_out    <= RST_DAY;
      end else begin
         idx        <= idx_nxt;
         tmo_cnt    <= tmo_cnt_nxt;
         load_pulse <= load_nxt;
         frame_err  <= err_nxt;
         if (load_nxt) begin
            year_out  <= chk_yy;
            month_out <= chk_mm;
            day_out   <= chk_dd;
         end
      end
   end

   // Digit storage; ASCII '0'..'9' carry their value in the low nibble
   always_ff @(posedge clk) begin
      if (digit_we) digit[idx] <= rx_data[3:0];
   end

endmodule

// File: tb/tb_uart_date_parser.sv
// Bench for uart_date_parser: directed frames from the test plan followed by
// randomized date frames judged by a plain calendar model.
module tb_uart_date_parser;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic       rx_valid = 1'b0;
   logic [6:0] day_out, month_out, year_out;
   logic       load_pulse, frame_err, busy;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int n_load = 0, n_ferr = 0, n_both = 0, n_busy = 0;
   int last_load_cyc = -1, last_err_cyc = -1;
   int last_edge = 0;
   int exp_y = 24, exp_m = 2, exp_d = 2;

   uart_date_parser #(.TIMEOUT_CYCLES(16)) dut (
      .clk        (clk),
      .reset      (reset),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .day_out    (day_out),
      .month_out  (month_out),
      .year_out   (year_out),
      .load_pulse (load_pulse),
      .frame_err  (frame_err),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Strobe monitor, sampled half a cycle after the active edge
   always @(negedge clk) begin
      if (load_pulse) begin
         n_load        <= n_load + 1;
         last_load_cyc <= cyc;
      end
      if (frame_err) begin
         n_ferr       <= n_ferr + 1;
         last_err_cyc <= cyc;
      end
      if (load_pulse && frame_err) n_both <= n_both + 1;
      if (busy) n_busy <= n_busy + 1;
   end

   task automatic check(input string tag, input int obs, input int expv);
      n_cmp++;
      assert (obs === expv)
      else begin
         n_bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic drive(input byte b);
      @(negedge clk);
      rx_data   = b;
      rx_valid  = 1'b1;
      last_edge = cyc + 1;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         rx_valid = 1'b0;
      end
   endtask

   task automatic send_str(input string s, input int gap);
      for (int i = 0; i < s.len(); i++) begin
         drive(s[i]);
         if (gap > 0) idle(gap);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset    = 1'b1;
      rx_valid = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      exp_y = 24; exp_m = 2; exp_d = 2;
   endtask

   // Calendar model: plain month-length table plus the four-year leap rule
   function automatic bit date_ok(input int yy, input int mm, input int dd);
      int ml [12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
      int lim;
      if (mm < 1 || mm > 12) return 1'b0;
      lim = ml[mm-1];
      if (mm == 2 && (yy % 4) == 0) lim = 29;
      return (dd >= 1) && (dd <= lim);
   endfunction

   task automatic run_frame(input string s, input int gap, input bit exp_load,
                            input int ey, input int em, input int ed,
                            input string tag);
      int l0, e0;
      l0 = n_load;
      e0 = n_ferr;
      send_str(s, gap);
      idle(4);
      check({tag, "_loads"}, n_load - l0, exp_load ? 1 : 0);
      check({tag, "_errs"}, n_ferr - e0, exp_load ? 0 : 1);
      if (exp_load) begin
         check({tag, "_load_lat"}, last_load_cyc, last_edge + 1);
         exp_y = ey; exp_m = em; exp_d = ed;
      end else begin
         check({tag, "_err_lat"}, last_err_cyc, last_edge + 1);
      end
      check({tag, "_year"}, int'(year_out), exp_y);
      check({tag, "_month"}, int'(month_out), exp_m);
      check({tag, "_day"}, int'(day_out), exp_d);
      check({tag, "_busy"}, int'(busy), 0);
   endtask

   initial begin
      int l0, e0, b0, yy, mm, dd;
      bit ok;
      string s;

      do_reset();
      check("rst_year", int'(year_out), 24);
      check("rst_month", int'(month_out), 2);
      check("rst_day", int'(day_out), 2);
      check("rst_load", int'(load_pulse), 0);
      check("rst_ferr", int'(frame_err), 0);
      check("rst_busy", int'(busy), 0);

      run_frame("D240229\r", 1, 1'b1, 24, 2, 29, "leap_ok");

      do_reset();
      run_frame("D230229\r", 1, 1'b0, 0, 0, 0, "nonleap");
      run_frame("D241331\r", 0, 1'b0, 0, 0, 0, "month13");

      run_frame("D24D241231\r", 1, 1'b1, 24, 12, 31, "restart");

      // Bad byte inside the digit field
      e0 = n_ferr; l0 = n_load;
      send_str("D24X", 0);
      idle(3);
      check("badbyte_errs", n_ferr - e0, 1);
      check("badbyte_err_at", last_err_cyc, last_edge);
      check("badbyte_loads", n_load - l0, 0);
      check("badbyte_busy", int'(busy), 0);

      // Inter-byte timeout
      e0 = n_ferr;
      send_str("D24", 0);
      idle(25);
      check("tmo_errs", n_ferr - e0, 1);
      check("tmo_err_at", last_err_cyc, last_edge + 15);
      check("tmo_busy", int'(busy), 0);
      run_frame("D000101\r", 2, 1'b1, 0, 1, 1, "after_tmo");

      // Reset in the middle of a frame
      send_str("D2412", 1);
      do_reset();
      check("midrst_busy", int'(busy), 0);
      l0 = n_load; e0 = n_ferr;
      send_str("31\r", 1);
      idle(4);
      check("midrst_loads", n_load - l0, 0);
      check("midrst_errs", n_ferr - e0, 0);
      check("midrst_year", int'(year_out), 24);
      check("midrst_month", int'(month_out), 2);
      check("midrst_day", int'(day_out), 2);
      run_frame("D250715\r", 1, 1'b1, 25, 7, 15, "post_rst");

      // Garbage while idle
      l0 = n_load; e0 = n_ferr; b0 = n_busy;
      send_str("xyz\r", 0);
      idle(4);
      check("garbage_loads", n_load - l0, 0);
      check("garbage_errs", n_ferr - e0, 0);
      check("garbage_busy", n_busy - b0, 0);

      run_frame("D991130\r", 0, 1'b1, 99, 11, 30, "b2b");

      // Randomized frames, including out-of-range months and days
      for (int k = 0; k < 30; k++) begin
         yy = $urandom_range(0, 99);
         mm = $urandom_range(0, 14);
         dd = $urandom_range(0, 33);
         if (k % 3 == 0) mm = 2;
         ok = date_ok(yy, mm, dd);
         s = $sformatf("D%02d%02d%02d\r", yy, mm, dd);
         run_frame(s, $urandom_range(0, 4), ok, yy, mm, dd, $sformatf("rnd%0d", k));
      end

      check("never_both", n_both, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/uart_date_parser.md
Name: uart_date_parser

Overview:
Sits directly upstream of the calendar counter. It consumes bytes from the UART receiver and parses an ASCII date-set frame of the form 'D' YY MM DD CR. It validates the date against month length and the leap-year rule. On a valid frame it presents binary day/month/year with a one-cycle load strobe, which drives the calendar's set/uart_sign load path.

Parameters:
TIMEOUT_CYCLES, 50_000_000, max idle cycles between bytes inside a frame before abort (1 s at 50 MHz)
HDR_CHAR, 8'h44, frame header byte ('D')
TERM_CHAR, 8'h0D, frame terminator byte (CR)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
rx_data  in  8  received byte from UART RX
rx_valid  in  1  one-cycle strobe, rx_data valid
day_out  out  7  parsed day, binary 1..31
month_out  out  7  parsed month, binary 1..12
year_out  out  7  parsed year, binary 0..99
load_pulse  out  1  one-cycle strobe: new date valid on outputs
frame_err  out  1  one-cycle strobe: frame rejected
busy  out  1  high while a frame is in progress (any state except IDLE)

Behaviour:
- Reset (sampled on posedge clk while reset=1):
  - state=IDLE, digit index=0, timeout counter=0.
  - year_out=24, month_out=2, day_out=2 (matches calendar reset date).
  - load_pulse=0, frame_err=0.
- Reset mid-frame: partial frame discarded; no strobes are emitted.
- States: IDLE, DIGITS, TERM, CHECK.
- IDLE:
  - rx_valid with rx_data==HDR_CHAR -> DIGITS, index=0.
  - All other bytes are ignored silently.
- DIGITS, on each rx_valid:
  - ASCII '0'..'9' (0x30..0x39): store (rx_data-0x30) in digit[index], index++. After the 6th digit -> TERM.
  - HDR_CHAR: restart, index=0, stay in DIGITS, no error.
  - Any other byte: frame_err pulse, -> IDLE.
- TERM, on rx_valid:
  - TERM_CHAR -> CHECK.
  - Any other byte (including HDR_CHAR): frame_err pulse, -> IDLE.
- CHECK lasts exactly one cycle, then -> IDLE.
  - yy = 10*d0+d1, mm = 10*d2+d3, dd = 10*d4+d5.
  - Valid iff 1<=mm<=12 and 1<=dd<=dim(mm,yy).
  - dim: 31 for months 1,3,5,7,8,10,12; 30 for months 4,6,9,11; month 2 gives 29 if yy%4==0 (00 is leap), else 28.
  - Valid: outputs updated and load_pulse=1 on the edge leaving CHECK.
  - Invalid: frame_err=1, outputs unchanged.
- rx_valid during CHECK is dropped.
- Latency: CR sampled at edge E. Outputs and load_pulse are visible after edge E+1 and stay high for exactly one cycle.
- Timeout:
  - In DIGITS/TERM the counter increments each cycle without rx_valid and clears on each rx_valid.
  - When it reaches TIMEOUT_CYCLES-1: frame_err pulse, -> IDLE.
  - Counter width is clog2(TIMEOUT_CYCLES). The counter is held at 0 in IDLE/CHECK.
- load_pulse and frame_err are never high in the same cycle.
- Outputs hold their last valid date indefinitely.
- Arithmetic:
  - Digits are 4-bit.
  - Products are computed at 7-bit width; the max of 99 fits.
  - Comparisons are unsigned.

Decomposition:
- Package uart_date_pkg:
  - state enum (IDLE, DIGITS, TERM, CHECK)
  - HDR/TERM default constants
  - ASCII_ZERO=8'h30
  - reset date constants (24, 2, 2)
  - function days_in_month(month, year)
- Sub-module date_check: combinational. Inputs are six digits; outputs are yy/mm/dd binary and a valid flag. This keeps the FSM free of arithmetic and is reused by a future UART date-readback path.

Test Plan:
- "D240229\r" -> year_out=24, month_out=2, day_out=29; load_pulse high exactly 1 cycle, 1 edge after CR edge; frame_err stays 0.
- "D230229\r" then "D241331\r" -> frame_err pulse on each; outputs remain at the previous valid/reset values (24/2/2 from reset); no load_pulse.
- "D24D241231\r" (header restart) -> 24/12/31 loaded. "D24X" -> frame_err on the 'X' byte, busy falls.
- TIMEOUT_CYCLES=16: send "D24", then idle -> frame_err 15 cycles after the last byte; a subsequent "D000101\r" loads 0/1/1.
- Assert reset mid-frame after "D2412", then send "31\r" -> no load_pulse and no frame_err; outputs 24/2/2; a following full frame loads correctly.
- Garbage in IDLE ("xyz\r") -> no strobes; busy stays 0. Back-to-back rx_valid every cycle for "D991130\r" -> 99/11/30.
